// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter driving a one-hot AND/OR 4:1 mux into a
// registered valid/ready output stage; the granted requester drops to lowest priority.
module rr_mux_arbiter_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    logic [1:0]       ptr;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             found;
    logic             load;
    logic             any;
    logic             take;
    logic [3:0]       grant;
    logic [WIDTH-1:0] mux_out;

    assign load = ~out_valid | out_ready;
    assign any  = |req_valid;
    assign take = load & any;

    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant = 4'b0000;
        if (take) begin
            grant[pick] = 1'b1;
        end
    end

    // rst_n gates the handshake so no requester sees an accept the edge will never take
    assign req_ready = grant & {4{rst_n}};

    assign mux_out = (req_data0 & {WIDTH{grant[0]}})
                   | (req_data1 & {WIDTH{grant[1]}})
                   | (req_data2 & {WIDTH{grant[2]}})
                   | (req_data3 & {WIDTH{grant[3]}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ptr       <= 2'd0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_src   <= pick;
            ptr       <= pick + 2'd1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Self-checking bench for rr_mux_arbiter_4: a reference model predicts grants and
// pushes expected beats to a scoreboard queue that is compared against out_*.
module tb_rr_mux_arbiter_4;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [WIDTH-1:0] d [4];
    logic [3:0]       req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    logic             m_valid;
    logic [1:0]       m_ptr;
    logic [5:0]       sb[$];
    logic [3:0]       obs_rdy;
    logic [WIDTH-1:0] obs_data;
    logic             obs_valid;

    rr_mux_arbiter_4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data0 (d[0]),
        .req_data1 (d[1]),
        .req_data2 (d[2]),
        .req_data3 (d[3]),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered and left on a falling edge; predicts, checks, then advances one cycle.
    task automatic drive_cycle(input logic [3:0] v, input logic ordy);
        logic       ld;
        logic [1:0] pk;
        logic [1:0] ix;
        logic       found;
        logic [3:0] exp_rdy;
        logic [5:0] exp_beat;
        req_valid = v;
        out_ready = ordy;
        #1;
        ld    = !m_valid || ordy;
        pk    = m_ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ix = m_ptr + 2'(k);
            if (!found && v[ix]) begin
                pk    = ix;
                found = 1'b1;
            end
        end
        exp_rdy = (ld && (|v)) ? (4'b0001 << pk) : 4'b0000;
        obs_rdy = req_ready;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b (valid %b ptr %0d)", req_ready, exp_rdy, v, m_ptr);
        end
        if (m_valid && ordy && sb.size() > 0) void'(sb.pop_front());
        if (ld && (|v)) begin
            sb.push_back({pk, d[pk]});
            m_valid = 1'b1;
            m_ptr   = pk + 2'd1;
        end else if (ld) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        obs_valid = out_valid;
        obs_data  = out_data;
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_valid);
        end
        if (m_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got empty queue expected one beat");
            end else begin
                exp_beat = sb[0];
                if ({out_src, out_data} !== exp_beat) begin
                    errors++;
                    $display("FAIL out_beat: got src %0d data %h expected src %0d data %h",
                             out_src, out_data, exp_beat[5:4], exp_beat[3:0]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        req_valid = 4'b0000;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || out_src !== 2'd0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_state: got v%b d%h s%0d r%b expected v0 d0 s0 r0000",
                         out_valid, out_data, out_src, req_ready);
            end
        end
        rst_n = 1'b1;
        drive_cycle(4'b0000, 1'b1);
        checks++;
        if (obs_valid !== 1'b0 || obs_data !== '0 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got v%b d%h s%0d expected v0 d0 s0", obs_valid, obs_data, out_src);
        end
    endtask

    task automatic test_single();
        d[0] = 4'h1; d[1] = 4'h5; d[2] = 4'hc; d[3] = 4'h9;
        drive_cycle(4'b0100, 1'b1);
        checks++;
        if (obs_rdy !== 4'b0100 || obs_data !== 4'hc || out_src !== 2'd2) begin
            errors++;
            $display("FAIL single_req: got r%b d%h s%0d expected r0100 dc s2", obs_rdy, obs_data, out_src);
        end
        drive_cycle(4'b0000, 1'b1);
    endtask

    task automatic test_rotate();
        logic [WIDTH-1:0] exp_seq [5];
        logic [WIDTH-1:0] got;
        exp_seq[0] = 4'ha; exp_seq[1] = 4'hb; exp_seq[2] = 4'hc; exp_seq[3] = 4'hd; exp_seq[4] = 4'ha;
        d[0] = 4'ha; d[1] = 4'hb; d[2] = 4'hc; d[3] = 4'hd;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(4'b1111, 1'b1);
            got = obs_data;
            checks++;
            if (obs_valid !== 1'b1 || got !== exp_seq[i]) begin
                errors++;
                $display("FAIL rotate[%0d]: got v%b d%h expected v1 d%h", i, obs_valid, got, exp_seq[i]);
            end
        end
        drive_cycle(4'b0000, 1'b1);
    endtask

    task automatic test_back_pressure();
        d[0] = 4'h2; d[1] = 4'h7; d[2] = 4'h3; d[3] = 4'h4;
        drive_cycle(4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(4'b1111, 1'b0);
            checks++;
            if (obs_rdy !== 4'b0000 || obs_data !== 4'h7 || out_src !== 2'd1 || obs_valid !== 1'b1) begin
                errors++;
                $display("FAIL back_pressure[%0d]: got r%b d%h s%0d expected r0000 d7 s1", i, obs_rdy, obs_data, out_src);
            end
        end
        drive_cycle(4'b1111, 1'b1);
        checks++;
        if ($countones(obs_rdy) != 1) begin
            errors++;
            $display("FAIL release_onehot: got r%b expected exactly one bit", obs_rdy);
        end
        drive_cycle(4'b0000, 1'b1);
    endtask

    task automatic test_fairness_wrap();
        d[0] = 4'he; d[1] = 4'h6; d[2] = 4'h8; d[3] = 4'hf;
        drive_cycle(4'b1000, 1'b1);
        drive_cycle(4'b1001, 1'b1);
        checks++;
        if (obs_rdy !== 4'b0001 || out_src !== 2'd0) begin
            errors++;
            $display("FAIL wrap_to_0: got r%b s%0d expected r0001 s0", obs_rdy, out_src);
        end
        drive_cycle(4'b1001, 1'b1);
        checks++;
        if (obs_rdy !== 4'b1000 || out_src !== 2'd3) begin
            errors++;
            $display("FAIL then_3: got r%b s%0d expected r1000 s3", obs_rdy, out_src);
        end
        drive_cycle(4'b0000, 1'b1);
    endtask

    task automatic test_reset_mid();
        d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
        drive_cycle(4'b0001, 1'b1);
        drive_cycle(4'b0010, 1'b1);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got v%b r%b expected v0 r0000", out_valid, req_ready);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(4'b1111, 1'b1);
        checks++;
        if (obs_rdy !== 4'b0001 || out_src !== 2'd0 || obs_data !== 4'h1) begin
            errors++;
            $display("FAIL first_after_reset: got r%b s%0d d%h expected r0001 s0 d1", obs_rdy, out_src, obs_data);
        end
        drive_cycle(4'b0000, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        d[0] = '0; d[1] = '0; d[2] = '0; d[3] = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_reset();
        test_rotate();
        test_back_pressure();
        test_fairness_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
